load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the core datapath and the word-organised data memory. It accepts one RV32I load or store request at a time and translates byte, halfword and word accesses into word-index reads and full-word writes. Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended, and misaligned or illegal accesses are flagged instead of reaching memory.

## Interface
- `Data_Width`, 32: data word width. Fixed at 32 for RV32I.
- `Index_Width`, 30: width of the memory word index, taken from `Addr[31:2]`.
- `CLK`, input, 1: clock. Every state change happens on the rising edge.
- `RST`, input, 1: reset, synchronous and active-low.
- `Req`, input, 1: request valid. Sampled only while `Ready`=1.
- `MemWrite`, input, 1: 1 = store, 0 = load.
- `Funct3`, input, 3: access type, RISC-V encoding.
- `Addr`, input, 32: byte address.
- `StoreData`, input, 32: store data. Only the low bytes are used for SB and SH.
- `Ready`, output, 1: unit is idle and can accept a request.
- `Done`, output, 1: one-cycle completion pulse.
- `Err`, output, 1: valid only while `Done`=1. Set for a misaligned or illegal access.
- `LoadData`, output, 32: extended load result. Holds its value until the next successful load completes.
- `Mem_A`, output, `Index_Width`: word index driven to data memory.
- `Mem_WE`, output, 1: memory write enable.
- `Mem_WD`, output, 32: memory write data.
- `Mem_RD`, input, 32: combinational read data from memory at `Mem_A`.

## Operation
- **States:** IDLE, READ, WRITE, RESP.
- **Output decode:**
  - `Ready` = (state==IDLE).
  - `Done` = (state==RESP).
  - `Mem_WE` = (state==WRITE) & `RST`.
- **Acceptance:** on a rising edge with state==IDLE and `Req`=1, the unit latches `MemWrite`, `Funct3`, `Addr` and `StoreData`. A `Req` seen in any other state is ignored and not queued.
- **Legal loads:** LB 000, LH 001, LW 010, LBU 100, LHU 101.
- **Legal stores:** SB 000, SH 001, SW 010.
- **Illegal accesses:** any other `Funct3` value, a halfword access with `Addr[0]`=1, or a word access with `Addr[1:0]`≠0. All go IDLE → RESP with `Err`=1. No memory write happens and `LoadData` is unchanged.
- **Loads:** IDLE → READ → RESP.
  - In READ, `Mem_RD` is captured at the end of the cycle.
  - The byte lane is selected by `Addr[1:0]` and the halfword lane by `Addr[1]`.
  - LB and LH sign-extend from bit 7 or bit 15. LBU and LHU zero-extend.
- **SW:** IDLE → WRITE → RESP. `Mem_WD` = `StoreData`.
- **SB and SH:** IDLE → READ → WRITE → RESP.
  - READ captures the old word.
  - WRITE drives the old word with the addressed lane replaced by `StoreData[7:0]` or `StoreData[15:0]`. All other bytes are preserved.
- **Other state transitions:** WRITE → RESP and RESP → IDLE, unconditionally.
- **Memory address:** `Mem_A` = latched `Addr[31:2]` in every state. It is 0 after reset until the first acceptance.
- **`Mem_WD` outside WRITE:** holds its last value. It is don't-care to memory because `Mem_WE`=0.
- **Reset** (`RST`=0 at a rising edge), from any state:
  - state → IDLE.
  - `LoadData`, `Mem_WD`, the latched request and `Mem_A` → 0.
  - `Err` → 0.
- **Reset while in WRITE:** `Mem_WE` is gated low by `RST` during that cycle, so no partial write occurs.

## Timing
- Latency is counted from the accepting edge to the cycle in which `Done`=1:
  - Illegal or misaligned access: 1 cycle.
  - Load or SW: 2 cycles.
  - SB or SH: 3 cycles.
- A load's `LoadData` is valid in the `Done` cycle and remains stable afterwards.
- A store's memory write commits on the edge that ends the WRITE cycle. It is visible on `Mem_RD` in the `Done` cycle.
- `Ready` rises in the cycle after `Done`. The earliest next acceptance is the edge ending that first IDLE cycle.
- Throughput is one request per latency + 1 cycles.
- `Mem_WE` is high for exactly one cycle per legal store and is never high for a load or an illegal access.

## Test plan
- **Sign-extended byte and halfword loads.** Preload memory word 5 = 0x8899AABB.
  - LB at `Addr` 0x14 → `Done` 2 cycles after acceptance, `LoadData`=0xFFFFFFBB.
  - LH at 0x16 → `LoadData`=0xFFFF8899.
- **Zero-extended and word loads.** Same word 5 = 0x8899AABB.
  - LBU at 0x17 → `LoadData`=0x00000088.
  - LHU at 0x14 → 0x0000AABB.
  - LW at 0x14 → 0x8899AABB.
- **Sub-word stores.** Word 5 = 0x8899AABB.
  - SB with `StoreData`=0x12345655 at 0x15 → `Mem_WE` pulses once on cycle 2 with `Mem_WD`=0x889955BB. `Done` on cycle 3.
  - SH with `StoreData`=0xCAFE at 0x16 then yields word 0xCAFE55BB.
- **Misaligned and illegal accesses.**
  - LW at 0x16 → `Done`=1 and `Err`=1 in cycle 1, `Mem_WE` never asserted, `LoadData` unchanged.
  - `Funct3`=011 load → same response.
- **Requests while busy.** Hold `Req`=1 continuously with a different `Addr` during a busy LW → the second request is accepted only after `Ready` returns. `Done` pulses exactly once per accepted request.
- **Reset mid-operation.** Issue an SB and drive `RST`=0 during the WRITE cycle → `Mem_WE`=0 in that cycle, memory is unchanged, and after the edge state=IDLE, `Ready`=1, `Done`=0, `LoadData`=0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Multi-cycle RV32I load/store unit. It sits between the core and a
// word-organised data memory, and it handles one request at a time.
// Sub-word stores are done as read-modify-write. Loads are sign- or
// zero-extended. A misaligned or illegal access is answered with Err and
// never reaches memory.
//
// Ports
//   CLK, RST         clock, synchronous active-low reset
//   Req              request valid (sampled only while Ready)
//   MemWrite         1 = store, 0 = load
//   Funct3           RISC-V access type
//   Addr             byte address
//   StoreData        store data (low bytes used for SB/SH)
//   Ready            idle, can accept a request
//   Done             one-cycle completion pulse
//   Err              misaligned/illegal access flag, valid with Done
//   LoadData         extended load result, held until the next good load
//   Mem_A            word index to memory (latched Addr[31:2])
//   Mem_WE           memory write enable
//   Mem_WD           memory write data
//   Mem_RD           combinational memory read data at Mem_A
//
// state | meaning
// IDLE  | waiting for a request
// READ  | memory word at Mem_A captured at end of cycle
// WRITE | full word driven to memory, committed at end of cycle
// RESP  | Done pulse, Err valid
module load_store_unit #(
  parameter int Data_Width  = 32,
  parameter int Index_Width = 30
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Req,
  input  logic                   MemWrite,
  input  logic [2:0]             Funct3,
  input  logic [31:0]            Addr,
  input  logic [Data_Width-1:0]  StoreData,
  output logic                   Ready,
  output logic                   Done,
  output logic                   Err,
  output logic [Data_Width-1:0]  LoadData,
  output logic [Index_Width-1:0] Mem_A,
  output logic                   Mem_WE,
  output logic [Data_Width-1:0]  Mem_WD,
  input  logic [Data_Width-1:0]  Mem_RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                 state, state_nxt;
  logic                   we_q;
  logic [2:0]             f3_q;
  logic [31:0]            addr_q;
  logic [Data_Width-1:0]  sd_q;
  logic                   err_q;
  logic [Data_Width-1:0]  ld_q;
  logic [Data_Width-1:0]  wd_q;

  logic                   access_ok;
  logic [4:0]             byte_base;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;
  logic [Data_Width-1:0]  load_ext;
  logic [Data_Width-1:0]  merged;

  // Legality of the request presented at the IDLE edge.
  always_comb begin
    access_ok = 1'b0;
    case (Funct3)
      F3_B:    access_ok = 1'b1;
      F3_H:    access_ok = ~Addr[0];
      F3_W:    access_ok = (Addr[1:0] == 2'b00);
      F3_BU:   access_ok = ~MemWrite;
      F3_HU:   access_ok = ~MemWrite & ~Addr[0];
      default: access_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Req) begin
          if (!access_ok)                      state_nxt = RESP;
          else if (MemWrite && Funct3 == F3_W) state_nxt = WRITE;
          else                                 state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores,
  // both working on the word read during READ.
  always_comb begin
    byte_base = {addr_q[1:0], 3'b000};
    rd_byte   = Mem_RD[byte_base +: 8];
    rd_half   = addr_q[1] ? Mem_RD[31:16] : Mem_RD[15:0];

    load_ext = Mem_RD;
    case (f3_q)
      F3_B:    load_ext = {{(Data_Width-8){rd_byte[7]}}, rd_byte};
      F3_H:    load_ext = {{(Data_Width-16){rd_half[15]}}, rd_half};
      F3_BU:   load_ext = {{(Data_Width-8){1'b0}}, rd_byte};
      F3_HU:   load_ext = {{(Data_Width-16){1'b0}}, rd_half};
      default: load_ext = Mem_RD;
    endcase

    merged = Mem_RD;
    if (f3_q == F3_B)
      merged[byte_base +: 8] = sd_q[7:0];
    else if (addr_q[1])
      merged[31:16] = sd_q[15:0];
    else
      merged[15:0] = sd_q[15:0];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      f3_q   <= 3'b000;
      addr_q <= '0;
      sd_q   <= '0;
      err_q  <= 1'b0;
      ld_q   <= '0;
      wd_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Req) begin
        we_q   <= MemWrite;
        f3_q   <= Funct3;
        addr_q <= Addr;
        sd_q   <= StoreData;
        err_q  <= ~access_ok;
        // SW skips READ, so its write word is ready by the WRITE cycle.
        if (access_ok && MemWrite && Funct3 == F3_W)
          wd_q <= StoreData;
      end
      if (state == READ) begin
        if (we_q) wd_q <= merged;
        else      ld_q <= load_ext;
      end
    end
  end

  assign Ready    = (state == IDLE);
  assign Done     = (state == RESP);
  assign Err      = (state == RESP) & err_q;
  assign LoadData = ld_q;
  assign Mem_A    = addr_q[2 +: Index_Width];
  // RST gating stops a write from landing in the cycle the unit is reset.
  assign Mem_WE   = (state == WRITE) & RST;
  assign Mem_WD   = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Req = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Addr = 32'h0;
  logic [31:0] StoreData = 32'h0;
  logic        Ready, Done, Err, Mem_WE;
  logic [31:0] LoadData, Mem_WD, Mem_RD;
  logic [29:0] Mem_A;

  load_store_unit #(.Data_Width(32), .Index_Width(30)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .MemWrite(MemWrite), .Funct3(Funct3),
    .Addr(Addr), .StoreData(StoreData), .Ready(Ready), .Done(Done), .Err(Err),
    .LoadData(LoadData), .Mem_A(Mem_A), .Mem_WE(Mem_WE), .Mem_WD(Mem_WD),
    .Mem_RD(Mem_RD)
  );

  always #5 CLK = ~CLK;

  // Data memory seen by the DUT.
  logic [31:0] mem [0:63];
  assign Mem_RD = mem[Mem_A[5:0]];
  always @(posedge CLK) if (Mem_WE) mem[Mem_A[5:0]] <= Mem_WD;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle-time %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, described by the cycle
  // numbers at which things must happen.
  logic [31:0] ref_mem [0:63];
  int          cyc = 0;
  bit          inflight = 0;
  int          done_cyc = 0;
  int          we_cyc = -10;
  int          last_acc_cyc = 0;
  bit          exp_err = 0;
  logic [31:0] exp_wd = 0;
  logic [31:0] pend_ld = 0;
  bit          ld_pending = 0;
  logic [31:0] model_ld = 0;
  logic [29:0] model_idx = 0;
  int          n_acc = 0, n_cancel = 0, n_done = 0;
  bit          chk_on = 0;

  function automatic bit legal(bit we, logic [2:0] f3, logic [1:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return !a[0];
      3'd2:    return a == 2'd0;
      3'd4:    return !we;
      3'd5:    return !we && !a[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] w, logic [2:0] f3, logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(logic [31:0] w, logic [2:0] f3, logic [1:0] a,
                                            logic [31:0] sd);
    logic [31:0] mask, sh;
    if (f3 == 3'd2) return sd;
    if (f3 == 3'd0) begin
      mask = 32'hFF << (8 * a);
      sh   = sd << (8 * a);
    end else begin
      mask = 32'hFFFF << (16 * a[1]);
      sh   = sd << (16 * a[1]);
    end
    return (w & ~mask) | (sh & mask);
  endfunction

  always @(posedge CLK) begin
    int prev;
    logic [31:0] word;
    prev = cyc;
    cyc  = cyc + 1;
    if (!RST) begin
      if (inflight && prev < done_cyc) n_cancel++;
      inflight  = 0;
      model_ld  = 0;
      model_idx = 0;
    end else begin
      if (inflight && prev == we_cyc) ref_mem[model_idx[5:0]] = exp_wd;
      if (inflight && ld_pending && cyc == done_cyc) model_ld = pend_ld;
      if (!(inflight && prev <= done_cyc) && Req) begin
        n_acc++;
        last_acc_cyc = cyc;
        inflight   = 1;
        model_idx  = Addr[31:2];
        word       = ref_mem[Addr[7:2]];
        exp_err    = !legal(MemWrite, Funct3, Addr[1:0]);
        ld_pending = 0;
        we_cyc     = -10;
        if (exp_err) begin
          done_cyc = cyc;
        end else if (MemWrite) begin
          exp_wd   = store_val(word, Funct3, Addr[1:0], StoreData);
          done_cyc = (Funct3 == 3'd2) ? cyc + 1 : cyc + 2;
          we_cyc   = done_cyc - 1;
        end else begin
          pend_ld    = load_val(word, Funct3, Addr[1:0]);
          ld_pending = 1;
          done_cyc   = cyc + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    bit busy, exp_done;
    if (chk_on) begin
      busy     = inflight && cyc <= done_cyc;
      exp_done = inflight && cyc == done_cyc;
      chk("ready", {31'b0, Ready}, {31'b0, !busy});
      chk("done", {31'b0, Done}, {31'b0, exp_done});
      if (exp_done) chk("err", {31'b0, Err}, {31'b0, exp_err});
      chk("mem_we", {31'b0, Mem_WE}, {31'b0, inflight && cyc == we_cyc && RST});
      if (Mem_WE) chk("mem_wd", Mem_WD, exp_wd);
      chk("load_data", LoadData, model_ld);
      chk("mem_a", {2'b0, Mem_A}, {2'b0, model_idx});
      if (exp_done && !exp_err) chk("mem_rd", Mem_RD, ref_mem[model_idx[5:0]]);
      if (Done) n_done++;
    end
  end

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, output int lat);
    int n;
    n = 0;
    while (inflight && cyc <= done_cyc && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    Req = 1'b1; MemWrite = we; Funct3 = f3; Addr = a; StoreData = sd;
    @(posedge CLK); #1;
    Req = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (Done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc0, first_acc, n;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[5] = 32'h8899AABB; ref_mem[5] = 32'h8899AABB;
    mem[6] = 32'h01234567; ref_mem[6] = 32'h01234567;

    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk_on = 1;
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    chk("rst_ready", {31'b0, Ready}, 32'd1);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_ld", LoadData, 32'h0);
    chk("rst_mem_a", {2'b0, Mem_A}, 32'h0);

    issue(0, 3'd0, 32'h14, 0, lat);
    chk("lb_lat", lat, 2);
    chk("lb_val", LoadData, 32'hFFFFFFBB);
    issue(0, 3'd1, 32'h16, 0, lat);
    chk("lh_val", LoadData, 32'hFFFF8899);
    issue(0, 3'd4, 32'h17, 0, lat);
    chk("lbu_val", LoadData, 32'h00000088);
    issue(0, 3'd5, 32'h14, 0, lat);
    chk("lhu_val", LoadData, 32'h0000AABB);
    issue(0, 3'd2, 32'h14, 0, lat);
    chk("lw_val", LoadData, 32'h8899AABB);

    issue(1, 3'd0, 32'h15, 32'h12345655, lat);
    chk("sb_lat", lat, 3);
    chk("sb_mem", mem[5], 32'h889955BB);
    issue(1, 3'd1, 32'h16, 32'h0000CAFE, lat);
    chk("sh_mem", mem[5], 32'hCAFE55BB);
    issue(1, 3'd2, 32'h20, 32'hDEADBEEF, lat);
    chk("sw_lat", lat, 2);
    chk("sw_mem", mem[8], 32'hDEADBEEF);

    issue(0, 3'd2, 32'h16, 0, lat);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_err", {31'b0, Err}, 32'd1);
    chk("lw_mis_ld", LoadData, 32'h8899AABB);
    issue(0, 3'd3, 32'h14, 0, lat);
    chk("f3_011_lat", lat, 1);
    chk("f3_011_err", {31'b0, Err}, 32'd1);
    issue(1, 3'd1, 32'h15, 32'hFFFF, lat);
    chk("sh_mis_lat", lat, 1);
    chk("sh_mis_mem", mem[5], 32'hCAFE55BB);

    // Request held high across a busy LW with a different address.
    @(posedge CLK); #1;
    acc0 = n_acc;
    Req = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; Addr = 32'h14;
    @(posedge CLK); #1;
    first_acc = last_acc_cyc;
    Addr = 32'h18;
    n = 0;
    while (n_acc < acc0 + 2 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    Req = 1'b0;
    chk("busy_accepts", n_acc - acc0, 2);
    chk("busy_gap", last_acc_cyc - first_acc, 3);
    repeat (3) @(negedge CLK);
    chk("busy_ld", LoadData, 32'h01234567);

    // Reset during the WRITE cycle of an SB.
    @(posedge CLK); #1;
    Req = 1'b1; MemWrite = 1'b1; Funct3 = 3'd0; Addr = 32'h14; StoreData = 32'h77;
    @(posedge CLK); #1;
    Req = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_write_we", {31'b0, Mem_WE}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_ready", {31'b0, Ready}, 32'd1);
    chk("rst_mid_done", {31'b0, Done}, 32'd0);
    chk("rst_mid_ld", LoadData, 32'h0);
    chk("rst_mid_mem", mem[5], 32'hCAFE55BB);

    issue(0, 3'd0, 32'h14, 0, lat);
    chk("post_rst_lb", LoadData, 32'hFFFFFFBB);

    repeat (3) @(negedge CLK);
    chk("done_count", n_done, n_acc - n_cancel);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
